// File: rtl/axi4lite_fir_initiator.sv
`timescale 1ns/1ps
// axi4lite_fir_initiator
// Fabric-side AXI4-Lite initiator for the memory-mapped FIR peripheral.
// Taps and samples arrive on valid/ready streams. Each one is written to
// the FIR, samples are followed by polling the done bit, and the 16-bit
// result is read back onto the result stream. Only one sample is in flight.
module axi4lite_fir_initiator #(
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_TAPS           = 61,
  parameter int INIT_WAIT          = 64,
  parameter int POLL_LIMIT         = 1024
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [15:0]                       tap_data,
  input  logic                              tap_valid,
  output logic                              tap_ready,
  input  logic [15:0]                       smp_data,
  input  logic                              smp_valid,
  output logic                              smp_ready,
  output logic [15:0]                       res_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [5:0]                        tap_idx,
  output logic                              err_resp,
  output logic                              err_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW      = C_M_AXI_ADDR_WIDTH;
  localparam int DW      = C_M_AXI_DATA_WIDTH;
  localparam int INIT_CW = $clog2(INIT_WAIT + 1);
  localparam int POLL_CW = $clog2(POLL_LIMIT + 1);

  localparam logic [AW-1:0] ADDR_RESULT = AW'(8'h00);
  localparam logic [AW-1:0] ADDR_SAMPLE = AW'(8'h04);
  localparam logic [AW-1:0] ADDR_TAP    = AW'(8'h08);

  typedef enum logic [3:0] {
    WAIT_INIT, IDLE, TAP_W, TAP_B, SMP_W, SMP_B, POLL_A, POLL_R, RES_A, RES_R
  } state_t;

  state_t               state;
  logic [INIT_CW-1:0]   init_cnt;
  logic [POLL_CW-1:0]   poll_cnt;
  logic                 aw_done;
  logic                 w_done;
  logic                 unused_rdata;

  // The FIR takes 16-bit values left-justified by 8 bits and sign-extended.
  function automatic logic [DW-1:0] pack_word(input logic [15:0] d);
    pack_word = {{(DW-24){d[15]}}, d, 8'h00};
  endfunction

  // Stream accept strobes: a pending tap always wins, and a new sample is
  // held off while the previous result is still waiting on the output.
  assign tap_ready = (state == IDLE) && tap_valid;
  assign smp_ready = (state == IDLE) && !tap_valid && !res_valid;

  // A write channel is finished once its VALID has dropped or is being accepted now.
  assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

  assign M_AXI_WSTRB  = '1;
  assign unused_rdata = &{1'b0, M_AXI_RDATA[DW-1:16]};

  // Main sequencer: owns every bus-facing register and the result stream.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= WAIT_INIT;
      init_cnt      <= '0;
      poll_cnt      <= '0;
      tap_idx       <= '0;
      err_resp      <= 1'b0;
      err_timeout   <= 1'b0;
      res_data      <= '0;
      res_valid     <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;

      case (state)
        WAIT_INIT: begin
          if (init_cnt == INIT_CW'(INIT_WAIT - 1)) state <= IDLE;
          else init_cnt <= init_cnt + 1'b1;
        end

        IDLE: begin
          if (tap_ready) begin
            M_AXI_AWADDR  <= ADDR_TAP;
            M_AXI_WDATA   <= pack_word(tap_data);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= TAP_W;
          end else if (smp_ready && smp_valid) begin
            M_AXI_AWADDR  <= ADDR_SAMPLE;
            M_AXI_WDATA   <= pack_word(smp_data);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= SMP_W;
          end
        end

        TAP_W, SMP_W: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            M_AXI_BREADY <= 1'b1;
            state        <= (state == TAP_W) ? TAP_B : SMP_B;
          end
        end

        TAP_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != 2'b00) err_resp <= 1'b1;
            tap_idx <= (tap_idx == 6'(NUM_TAPS - 1)) ? 6'd0 : tap_idx + 6'd1;
            state   <= IDLE;
          end
        end

        SMP_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY  <= 1'b0;
            if (M_AXI_BRESP != 2'b00) err_resp <= 1'b1;
            poll_cnt      <= '0;
            M_AXI_ARADDR  <= ADDR_TAP;
            M_AXI_ARVALID <= 1'b1;
            state         <= POLL_A;
          end
        end

        POLL_A, RES_A: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= (state == POLL_A) ? POLL_R : RES_R;
          end
        end

        POLL_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            if (M_AXI_RRESP != 2'b00) err_resp <= 1'b1;
            if (M_AXI_RDATA[0]) begin
              M_AXI_ARADDR  <= ADDR_RESULT;
              M_AXI_ARVALID <= 1'b1;
              state         <= RES_A;
            end else if (poll_cnt == POLL_CW'(POLL_LIMIT - 1)) begin
              err_timeout <= 1'b1;
              state       <= IDLE;
            end else begin
              poll_cnt      <= poll_cnt + 1'b1;
              M_AXI_ARVALID <= 1'b1;
              state         <= POLL_A;
            end
          end
        end

        RES_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            if (M_AXI_RRESP != 2'b00) err_resp <= 1'b1;
            res_data  <= M_AXI_RDATA[15:0];
            res_valid <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
